ca_line_stepper: RTL
====================

# ca_line_stepper

Programmable elementary cellular-automaton line stepper. It reads one 1280-pixel line (80 × 16-bit words) from the image RAM read port and computes the next generation under an 8-bit Wolfram rule. It writes the result into the other line bank through the RAM write port. It sits directly upstream of the two-line image RAM feeding the scan-out filler, and is started once per scanline during horizontal blanking.

## Interface
- `WORDS`, 80, words per line
- `AW`, 8, RAM address width
- `DW`, 16, word width
- `BANK0`, 0, base address of line bank 0
- `BANK1`, 128, base address of line bank 1
- `WRAP`, 1, 1 = toroidal line edges; 0 = cells outside the line read as 0
- `clk`  in  1  pixel clock (108 MHz); all logic on rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `start`  in  1  single-cycle request to compute one line
- `direction`  in  1  0: read BANK0, write BANK1; 1: read BANK1, write BANK0
- `rule`  in  8  Wolfram rule number
- `read`  out  1  read enable to RAM port A
- `raddr`  out  AW  read address
- `rdata`  in  DW  read data
- `write`  out  1  write enable to RAM port B
- `waddr`  out  AW  write address
- `wdata`  out  DW  write data
- `busy`  out  1  high while a line is in progress
- `done`  out  1  one-cycle pulse after the last write

## Operation
- Pixel order:
  - word 0 is leftmost;
  - bit DW-1 of each word is its leftmost pixel.
- Update rule: `c'[x] = rule[{c[x-1], c[x], c[x+1]}]`, with `c[x-1]` as the MSB of the 3-bit index.
- Edge cells:
  - `WRAP=1`: the left neighbour of pixel 0 is pixel 1279; the right neighbour of pixel 1279 is pixel 0.
  - `WRAP=0`: both are 0.
- `start` is honoured only in IDLE. `direction` and `rule` are latched on the `start` edge. Changes to them while busy have no effect.
- States:
  - IDLE → PRIME on `start`.
  - PRIME: read word WORDS-1, only to capture the left-edge LSB. If `WRAP=0`, the read is still issued and its data is replaced by 0.
  - RUN: read words 0..WORDS-1, one per cycle. The MSB of word 0 is saved for the right edge.
  - DRAIN: write the final word.
  - DONE: assert `done` for one cycle → IDLE.
- Pipeline registers hold:
  - the previous word's LSB;
  - the current word;
  - the saved word-0 MSB.
- Word i is written once word i+1 has been captured. The last word uses the saved word-0 MSB, or 0 when `WRAP=0`.
- Exactly WORDS+1 reads and WORDS writes per line. Write addresses increase strictly from bank base+0 to bank base+WORDS-1.
- Address arithmetic: `base + index`, AW bits wide, with no wrap past the bank.
- Reset, including mid-line: return to IDLE.
  - `read`, `write`, `busy`, `done` = 0.
  - `raddr`, `waddr`, `wdata` = 0.
  - No further writes occur. A partially written line is left as is.

## Timing
- Every output is registered.
- RAM port A is clocked on the inverted clock, so `rdata` for a read asserted in cycle n is valid throughout cycle n+1.
- Relative to the `start` edge (cycle 0):
  - `read` is high for cycles 1..WORDS+1: cycle 1 = word WORDS-1, cycle k+2 = word k.
  - `write` for word i is high in cycle i+5, for i = 0..WORDS-1.
  - `busy` is high for cycles 1..WORDS+4.
  - `done` is high in cycle WORDS+5.
- Total latency is 85 cycles for WORDS=80. This fits within the 408-cycle horizontal blank.
- Reads and writes overlap in time but target disjoint banks, so there is no read-after-write hazard.
- `start` in the same cycle as `done` is ignored. The next accepted start is the cycle after `done`.

## Structure
- A shared package holds:
  - the state encoding (IDLE, PRIME, RUN, DRAIN, DONE);
  - the `BANK0`/`BANK1` constants;
  - `WORDS`.
- One sub-module: `ca_rule_word`. It is combinational and takes `left` bit, `word[DW-1:0]`, `right` bit and `rule[7:0]`, producing `next[DW-1:0]`. It is instantiated once and can be reused by the reset-seed and test logic.
- The top-level mux of this block's ports with the filler and reset generator stays outside this block.

## Test plan
- Rule 90, `WRAP=0`, `direction=0`, bank0 zero except word 39 = 0x0001 → bank1 word 39 = 0x0002, word 40 = 0x8000, all others 0. `done` at cycle 85.
- Rule 204 (identity), random bank0 contents → bank1 equals bank0 bit-exactly. 81 reads and 80 writes, with write addresses 128..207 in order.
- Rule 30, `WRAP=1`, bank1 word 0 = 0x8000, others 0, `direction=1` → bank0 word 0 = 0xC000, word 79 = 0x0001 (wrap). Repeat with `WRAP=0` → word 79 = 0.
- `start` pulsed at cycles 10 and 85, with `rule` changed mid-line → both pulses ignored. Exactly 80 writes, all using the latched rule.
- `rst_n` asserted at cycle 30 → all outputs 0 within the same cycle, with no writes afterward. The next `start` completes a full line correctly.
- All-ones line with rule 0 → all-zero output. All-zeros line with rule 1 → all 0xFFFF.

Source files
------------

// File: rtl/ca_line_stepper_pkg.sv
// ============================================================================
// ca_line_stepper_pkg : shared constants, state encoding and bank helper
// Revision: 1.0
// ============================================================================
`default_nettype none

package ca_line_stepper_pkg;

  localparam int WORDS = 80;
  localparam int AW    = 8;
  localparam int DW    = 16;

  localparam logic [AW-1:0] BANK0 = 8'd0;
  localparam logic [AW-1:0] BANK1 = 8'd128;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PRIME = 3'd1,
    ST_RUN   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  function automatic logic [AW-1:0] bank_base(input logic sel);
    return sel ? BANK1 : BANK0;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ca_line_stepper_if.sv
// ============================================================================
// ca_line_stepper_if : control handshake and RAM port bundle of the stepper
// Revision: 1.0
// ============================================================================
`default_nettype none

interface ca_line_stepper_if;
  import ca_line_stepper_pkg::*;

  logic          start;
  logic          direction;
  logic [7:0]    rule;
  logic          read;
  logic [AW-1:0] raddr;
  logic [DW-1:0] rdata;
  logic          write;
  logic [AW-1:0] waddr;
  logic [DW-1:0] wdata;
  logic          busy;
  logic          done;

  modport master (
    output start, direction, rule, rdata,
    input  read, raddr, write, waddr, wdata, busy, done
  );

  modport slave (
    input  start, direction, rule, rdata,
    output read, raddr, write, waddr, wdata, busy, done
  );

endinterface

`default_nettype wire

// File: rtl/ca_rule_word.sv
// ============================================================================
// ca_rule_word : one word of an elementary CA generation (bit DW-1 leftmost)
// Revision: 1.0
// ============================================================================
`default_nettype none

module ca_rule_word
  import ca_line_stepper_pkg::*;
(
  input  logic          left,
  input  logic [DW-1:0] word,
  input  logic          right,
  input  logic [7:0]    rule,
  output logic [DW-1:0] next
);

  logic [DW+1:0] ext;

  assign ext = {left, word, right};

  // ext[b+2] is the left neighbour of word[b], ext[b] the right one
  for (genvar b = 0; b < DW; b++) begin : g_bit
    assign next[b] = rule[ext[b+2 -: 3]];
  end

endmodule

`default_nettype wire

// File: rtl/ca_line_stepper.sv
// ============================================================================
// ca_line_stepper : reads one line from a RAM bank, writes its next CA generation
// Revision: 1.0
// ============================================================================
`default_nettype none

module ca_line_stepper
  import ca_line_stepper_pkg::*;
#(
  parameter bit WRAP = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  ca_line_stepper_if.slave bus
);

  // cycle numbers relative to the accepted start
  localparam logic [AW-1:0] CYC_LEFT       = AW'(3);
  localparam logic [AW-1:0] CYC_WORD0      = AW'(4);
  localparam logic [AW-1:0] CYC_WRITE0     = AW'(5);
  localparam logic [AW-1:0] CYC_LAST_READ  = AW'(WORDS + 1);
  localparam logic [AW-1:0] CYC_LAST_CAP   = AW'(WORDS + 3);
  localparam logic [AW-1:0] CYC_LAST_WRITE = AW'(WORDS + 4);

  state_t        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic          dir_q, dir_d;
  logic [7:0]    rule_q, rule_d;
  logic          read_q, read_d;
  logic [AW-1:0] raddr_q, raddr_d;
  logic          write_q, write_d;
  logic [AW-1:0] waddr_q, waddr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          left_q, left_d;
  logic [DW-1:0] cur_q, cur_d;
  logic          msb0_q, msb0_d;

  logic [AW-1:0] cnt_nxt;
  logic          right_bit;
  logic [DW-1:0] next_word;

  assign cnt_nxt   = cnt_q + AW'(1);
  assign right_bit = (cnt_nxt == CYC_LAST_WRITE) ? (WRAP ? msb0_q : 1'b0)
                                                 : bus.rdata[DW-1];

  ca_rule_word u_rule_word (
    .left  (left_q),
    .word  (cur_q),
    .right (right_bit),
    .rule  (rule_q),
    .next  (next_word)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    rule_d  = rule_q;
    read_d  = 1'b0;
    raddr_d = raddr_q;
    write_d = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    left_d  = left_q;
    cur_d   = cur_q;
    msb0_d  = msb0_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d = ST_PRIME;
          cnt_d   = AW'(1);
          dir_d   = bus.direction;
          rule_d  = bus.rule;
          read_d  = 1'b1;
          raddr_d = bank_base(bus.direction) + AW'(WORDS - 1);
          busy_d  = 1'b1;
        end
      end
      ST_PRIME: begin
        state_d = ST_RUN;
        cnt_d   = cnt_nxt;
        read_d  = 1'b1;
        raddr_d = bank_base(dir_q);
      end
      ST_RUN: begin
        cnt_d = cnt_nxt;
        if (cnt_nxt <= CYC_LAST_READ) begin
          read_d  = 1'b1;
          raddr_d = bank_base(dir_q) + (cnt_nxt - AW'(2));
        end
        if (cnt_nxt == CYC_LEFT) begin
          left_d = WRAP ? bus.rdata[0] : 1'b0;
        end
        if (cnt_nxt >= CYC_WORD0 && cnt_nxt <= CYC_LAST_CAP) begin
          cur_d = bus.rdata;
        end
        if (cnt_nxt == CYC_WORD0) begin
          msb0_d = bus.rdata[DW-1];
        end
        // word i goes out once word i+1 is on rdata
        if (cnt_nxt >= CYC_WRITE0) begin
          write_d = 1'b1;
          waddr_d = bank_base(!dir_q) + (cnt_nxt - CYC_WRITE0);
          wdata_d = next_word;
          left_d  = cur_q[0];
        end
        if (cnt_nxt == CYC_LAST_WRITE) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        state_d = ST_DONE;
        cnt_d   = cnt_nxt;
        busy_d  = 1'b0;
        done_d  = 1'b1;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
      rule_q  <= '0;
      read_q  <= 1'b0;
      raddr_q <= '0;
      write_q <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      left_q  <= 1'b0;
      cur_q   <= '0;
      msb0_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      rule_q  <= rule_d;
      read_q  <= read_d;
      raddr_q <= raddr_d;
      write_q <= write_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      left_q  <= left_d;
      cur_q   <= cur_d;
      msb0_q  <= msb0_d;
    end
  end

  assign bus.read  = read_q;
  assign bus.raddr = raddr_q;
  assign bus.write = write_q;
  assign bus.waddr = waddr_q;
  assign bus.wdata = wdata_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;

endmodule

`default_nettype wire
